janus_mem_ctrl: RTL and testbench
=================================

JANUS_MEM_CTRL -- requirements
Module: janus_mem_ctrl

Interface
REQ-001 Parameter PA_DATA_WIDTH, default 32: data bus width.
REQ-002 Parameter PA_ADDR_WIDTH, default 10: internal RAM address width; depth is 2**PA_ADDR_WIDTH words.
REQ-003 Parameter PA_WAIT_CYCLES, default 2, range 0..15: extra wait states on RAM read and write.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst_b, input, 1: asynchronous, active-low reset.
REQ-006 Port ab, input, 32: address bus from the CPU.
REQ-007 Port dob, input, PA_DATA_WIDTH: write data from the CPU.
REQ-008 Port cb_in, input, 3: CPU requests; bit 0 mar_wr, bit 1 ram_wr, bit 2 ram_oe.
REQ-009 Port halt, input, 1: CPU halted; blocks acceptance of new requests.
REQ-010 Port dib, output, PA_DATA_WIDTH: read data to the CPU.
REQ-011 Port cb_out, output, 3: acks; bit 0 mar_wr_ack, bit 1 ram_wr_ack, bit 2 ram_oe_ack.
REQ-012 Port mem_err, output, 1: out-of-range address flag (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, MAR_ACK, WR_WAIT, WR_ACK, RD_WAIT, RD_ACK.
REQ-014 Handshake is four-phase: request held high until its ack; ack held high until the request drops; FSM returns to IDLE on the edge that samples the request low.
REQ-015 In IDLE with halt low, simultaneous requests SHALL be arbitrated mar_wr > ram_wr > ram_oe; the losers remain pending.
REQ-016 mar_wr: on the accepting edge, MAR <= ab[PA_ADDR_WIDTH-1:0]; go to MAR_ACK; mar_wr_ack high from the next cycle.
REQ-017 ram_wr: go to WR_WAIT; a 4-bit wait counter runs PA_WAIT_CYCLES cycles; then RAM[MAR] <= dob, sampled on the write edge, and go to WR_ACK.
REQ-018 ram_oe: go to RD_WAIT; after PA_WAIT_CYCLES cycles, dib <= RAM[MAR] and go to RD_ACK.
REQ-019 Latency: request sampled at edge N gives ack visible after edge N+1+PA_WAIT_CYCLES (N+1 for mar_wr); PA_WAIT_CYCLES=0 SHALL skip the WAIT states.
REQ-020 dib SHALL hold the last read value until the next read completes.
REQ-021 At most one ack bit SHALL be high at any time.
REQ-022 Requests that drop before their ack SHALL NOT abort the access; the access completes, and the ack asserts for one cycle only.
REQ-023 halt high SHALL block new acceptance in IDLE only; an access in progress completes normally.
REQ-024 Upper address bits beyond PA_ADDR_WIDTH SHALL be ignored, so the address wraps modulo the depth, unless JANUS_MEM_BOUNDS_EN is defined.

Reset
REQ-025 rst_b low SHALL force state IDLE, cb_out 0, dib 0, MAR 0, wait counter 0 and mem_err 0, asynchronously, including mid-access.
REQ-026 RAM contents SHALL NOT be reset; an interrupted write SHALL leave its location unchanged.

Configuration
REQ-027 Macro JANUS_MEM_BOUNDS_EN, when defined: a MAR write with any ab bit at or above PA_ADDR_WIDTH set SHALL set mem_err. mem_err holds until the next MAR write.
REQ-028 With JANUS_MEM_BOUNDS_EN defined and mem_err high, a write SHALL be suppressed and a read SHALL return 0; both SHALL still be acked with normal timing.
REQ-029 Without JANUS_MEM_BOUNDS_EN, mem_err SHALL be tied to 0 and addresses wrap per REQ-024.

Structure
REQ-030 FSM state encodings, cb bit indices (CB_MAR, CB_WR, CB_OE) and the wait-counter width SHALL live in the shared package janus_pkg.
REQ-031 Storage SHALL be the sub-module janus_ram: single port, synchronous write, registered read.

Verification
REQ-032 Assert mar_wr with ab=0x0000_0005 -> mar_wr_ack high one cycle later; drop mar_wr -> ack low, FSM in IDLE.
REQ-033 With PA_WAIT_CYCLES=2 and MAR=5: ram_wr with dob=0xDEAD_BEEF, then ram_oe -> each ack appears exactly 3 cycles after its request; dib=0xDEAD_BEEF.
REQ-034 Assert mar_wr, ram_wr and ram_oe in the same cycle -> acks arrive in the order mar, wr, rd, never two high at once.
REQ-035 Pulse rst_b low during WR_WAIT with dob=0x1234 -> all outputs 0 immediately; a later read of that address returns the old value.
REQ-036 With JANUS_MEM_BOUNDS_EN defined: mar_wr with ab=0x0000_0400 (depth 1024) -> mem_err=1; a read returns 0. Without the macro -> mem_err=0 and the read returns RAM[0].
REQ-037 Assert halt high, then ram_oe -> no ack. Drop halt -> ack after 1+PA_WAIT_CYCLES cycles.

Source files
------------

// File: rtl/janus_pkg.sv
// Shared definitions for the janus memory controller.
//   - WAIT_W           : width of the wait-state counter
//   - CB_MAR/CB_WR/CB_OE : bit positions in the cb_in / cb_out request/ack buses
//   - state_e          : controller FSM state encoding
//   - ack_release()    : four-phase handshake release condition
package janus_pkg;

    localparam int WAIT_W = 4;

    localparam int CB_MAR = 0;
    localparam int CB_WR  = 1;
    localparam int CB_OE  = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAR_ACK = 3'd1,
        WR_WAIT = 3'd2,
        WR_ACK  = 3'd3,
        RD_WAIT = 3'd4,
        RD_ACK  = 3'd5
    } state_e;

    // An ack state is left only once the ack has been shown for at least one
    // cycle and the request is seen low. A request that was dropped early
    // therefore still receives a single-cycle ack.
    function automatic logic ack_release(input logic ack_q, input logic req);
        return ack_q && !req;
    endfunction

endpackage

// File: rtl/janus_ram.sv
// Single-port storage for the janus memory controller.
// Synchronous write, registered read; contents are never reset.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable (mem[addr] <= wdata)
//   re    - read enable  (rdata <= mem[addr])
//   addr  - word address
//   wdata - write data
//   rdata - registered read data, holds between reads
module janus_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/janus_mem_ctrl.sv
// CPU-facing memory controller with a four-phase request/ack handshake.
// A MAR write latches the word address; RAM write and read then use it,
// each inserting PA_WAIT_CYCLES wait states before completing.
// Optional feature macro: JANUS_MEM_BOUNDS_EN (flags out-of-range MAR writes,
// suppresses writes and zeroes reads while the flag is set).
// Ports:
//   clk     - clock, rising edge
//   rst_b   - asynchronous active-low reset
//   ab      - CPU address bus (only the low PA_ADDR_WIDTH bits address RAM)
//   dob     - CPU write data
//   cb_in   - requests: [0] mar_wr, [1] ram_wr, [2] ram_oe
//   halt    - blocks acceptance of new requests while in IDLE
//   dib     - read data, holds the last completed read
//   cb_out  - acks: [0] mar_wr_ack, [1] ram_wr_ack, [2] ram_oe_ack
//   mem_err - out-of-range address flag (0 unless JANUS_MEM_BOUNDS_EN)
module janus_mem_ctrl
    import janus_pkg::*;
#(
    parameter int PA_DATA_WIDTH  = 32,
    parameter int PA_ADDR_WIDTH  = 10,
    parameter int PA_WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [31:0]              ab,
    input  logic [PA_DATA_WIDTH-1:0] dob,
    input  logic [2:0]               cb_in,
    input  logic                     halt,
    output logic [PA_DATA_WIDTH-1:0] dib,
    output logic [2:0]               cb_out,
    output logic                     mem_err
);

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((PA_WAIT_CYCLES > 0) ? PA_WAIT_CYCLES - 1 : 0);

    state_e                   state_q, state_d;
    logic [PA_ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [WAIT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]               cb_out_q, cb_out_d;
    logic [PA_DATA_WIDTH-1:0] dib_q, dib_d;

    logic                     mar_load;
    logic                     ram_we;
    logic                     ram_re;
    logic                     err_active;
    logic [PA_DATA_WIDTH-1:0] ram_rdata;

`ifdef JANUS_MEM_BOUNDS_EN
    logic mem_err_q, mem_err_d;
    logic ab_hi_set;

    assign ab_hi_set = |ab[31:PA_ADDR_WIDTH];

    always_comb begin
        mem_err_d = mem_err_q;
        if (mar_load) begin
            mem_err_d = ab_hi_set;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= mem_err_d;
        end
    end

    assign err_active = mem_err_q;
`else
    // Upper address bits are intentionally discarded: addresses wrap.
    logic unused_ab_hi;
    assign unused_ab_hi = |ab[31:PA_ADDR_WIDTH];
    assign err_active   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        cnt_d    = cnt_q;
        cb_out_d = 3'b000;
        dib_d    = dib_q;
        mar_load = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!halt) begin
                    if (cb_in[CB_MAR]) begin
                        mar_d    = ab[PA_ADDR_WIDTH-1:0];
                        mar_load = 1'b1;
                        state_d  = MAR_ACK;
                    end else if (cb_in[CB_WR]) begin
                        cnt_d = '0;
                        if (PA_WAIT_CYCLES == 0) begin
                            ram_we  = 1'b1;
                            state_d = WR_ACK;
                        end else begin
                            state_d = WR_WAIT;
                        end
                    end else if (cb_in[CB_OE]) begin
                        cnt_d = '0;
                        if (PA_WAIT_CYCLES == 0) begin
                            ram_re  = 1'b1;
                            state_d = RD_ACK;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            MAR_ACK: begin
                cb_out_d[CB_MAR] = !ack_release(cb_out_q[CB_MAR], cb_in[CB_MAR]);
                if (ack_release(cb_out_q[CB_MAR], cb_in[CB_MAR])) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    ram_we  = 1'b1;
                    cnt_d   = '0;
                    state_d = WR_ACK;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            WR_ACK: begin
                cb_out_d[CB_WR] = !ack_release(cb_out_q[CB_WR], cb_in[CB_WR]);
                if (ack_release(cb_out_q[CB_WR], cb_in[CB_WR])) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    ram_re  = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_ACK;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            RD_ACK: begin
                // RAM output was registered on entry; capture it together
                // with the first ack cycle so dib is valid whenever ack is.
                if (!cb_out_q[CB_OE]) begin
                    dib_d = err_active ? '0 : ram_rdata;
                end
                cb_out_d[CB_OE] = !ack_release(cb_out_q[CB_OE], cb_in[CB_OE]);
                if (ack_release(cb_out_q[CB_OE], cb_in[CB_OE])) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            mar_q    <= '0;
            cnt_q    <= '0;
            cb_out_q <= 3'b000;
            dib_q    <= '0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            cnt_q    <= cnt_d;
            cb_out_q <= cb_out_d;
            dib_q    <= dib_d;
        end
    end

    janus_ram #(
        .DATA_W (PA_DATA_WIDTH),
        .ADDR_W (PA_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we && !err_active),
        .re    (ram_re),
        .addr  (mar_q),
        .wdata (dob),
        .rdata (ram_rdata)
    );

    assign dib     = dib_q;
    assign cb_out  = cb_out_q;
    assign mem_err = err_active;

endmodule

// File: tb/tb_janus_mem_ctrl.sv
module tb_janus_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int WC = 2;
    localparam int B_MAR = 0;
    localparam int B_WR  = 1;
    localparam int B_OE  = 2;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [31:0]   ab;
    logic [DW-1:0] dob;
    logic [2:0]    cb_in;
    logic          halt;
    logic [DW-1:0] dib;
    logic [2:0]    cb_out;
    logic          mem_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [int];

    always #5 clk = ~clk;

    janus_mem_ctrl #(
        .PA_DATA_WIDTH  (DW),
        .PA_ADDR_WIDTH  (AW),
        .PA_WAIT_CYCLES (WC)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .ab      (ab),
        .dob     (dob),
        .cb_in   (cb_in),
        .halt    (halt),
        .dib     (dib),
        .cb_out  (cb_out),
        .mem_err (mem_err)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ($countones(cb_out) > 1) begin
                n_fail++;
                $display("FAIL onehot_ack: cb_out=%b, required at most one bit set", cb_out);
            end
        end
    end

    // Raise request bit b, count edges until its ack, then drop it and let the
    // FSM return to IDLE. lat counts the sampling edge plus the wait.
    task automatic cpu_req(input int b, output int lat, output bit to);
        cb_in[b] = 1'b1;
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            lat++;
            if (cb_out[b]) begin
                to = 1'b0;
                break;
            end
        end
        cb_in[b] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_mar(input logic [31:0] a);
        int lat; bit to;
        ab = a;
        cpu_req(B_MAR, lat, to);
    endtask

    task automatic write_word(input logic [DW-1:0] d, input int addr);
        int lat; bit to;
        dob = d;
        cpu_req(B_WR, lat, to);
        model[addr] = d;
    endtask

    task automatic test_reset;
        logic [DW-1:0] zero_d;
        zero_d = '0;
        rst_b = 1'b0; ab = '0; dob = '0; cb_in = 3'b000; halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cb_out !== 3'b000) begin n_fail++; $display("FAIL reset_cb_out: got %b, required 000", cb_out); end
        n_checks++;
        if (dib !== zero_d) begin n_fail++; $display("FAIL reset_dib: got %h, required 0", dib); end
        n_checks++;
        if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b, required 0", mem_err); end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_mar;
        int lat; bit to;
        ab = 32'h0000_0005;
        cpu_req(B_MAR, lat, to);
        n_checks++;
        if (to || lat != 2) begin n_fail++; $display("FAIL mar_latency: got %0d edges (timeout=%0b), required 2", lat, to); end
        n_checks++;
        if (cb_out !== 3'b000) begin n_fail++; $display("FAIL mar_ack_drop: got %b, required 000", cb_out); end
    endtask

    task automatic test_write_read;
        int lat; bit to;
        logic [DW-1:0] e;
        dob = 32'hDEAD_BEEF;
        cpu_req(B_WR, lat, to);
        model[5] = 32'hDEAD_BEEF;
        n_checks++;
        if (to || lat != WC + 2) begin n_fail++; $display("FAIL wr_latency: got %0d edges (timeout=%0b), required %0d", lat, to, WC + 2); end
        exp_q.push_back(model[5]);
        cpu_req(B_OE, lat, to);
        n_checks++;
        if (to || lat != WC + 2) begin n_fail++; $display("FAIL rd_latency: got %0d edges (timeout=%0b), required %0d", lat, to, WC + 2); end
        e = exp_q.pop_front();
        n_checks++;
        if (dib !== e) begin n_fail++; $display("FAIL rd_data_5: got %h, required %h", dib, e); end
        // A second address; dib must hold across the unrelated write.
        set_mar(32'h0000_03FF);
        write_word(32'h0123_4567, 1023);
        n_checks++;
        if (dib !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dib_hold: got %h, required deadbeef", dib); end
        exp_q.push_back(model[1023]);
        cpu_req(B_OE, lat, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || dib !== e) begin n_fail++; $display("FAIL rd_data_3ff: got %h, required %h", dib, e); end
    endtask

    task automatic test_arbitration;
        int order [3];
        logic [DW-1:0] e;
        bit to;
        order = '{B_MAR, B_WR, B_OE};
        ab  = 32'h0000_0005;
        dob = 32'h5A5A_5A5A;
        model[5] = 32'h5A5A_5A5A;
        exp_q.push_back(32'h5A5A_5A5A);
        cb_in = 3'b111;
        for (int k = 0; k < 3; k++) begin
            to = 1'b1;
            for (int i = 0; i < 32; i++) begin
                @(posedge clk); #1;
                if (cb_out != 3'b000) begin to = 1'b0; break; end
            end
            n_checks++;
            if (to || cb_out !== (3'b001 << order[k])) begin
                n_fail++;
                $display("FAIL arb_order_%0d: got cb_out=%b (timeout=%0b), required %b", k, cb_out, to, 3'b001 << order[k]);
            end
            cb_in[order[k]] = 1'b0;
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++;
        if (dib !== e) begin n_fail++; $display("FAIL arb_rd_data: got %h, required %h", dib, e); end
    endtask

    task automatic test_reset_mid_write;
        int lat; bit to;
        logic [DW-1:0] e;
        logic [DW-1:0] zero_d;
        zero_d = '0;
        set_mar(32'h0000_0007);
        write_word(32'hCAFE_0007, 7);
        dob = 32'h0000_1234;
        cb_in[B_WR] = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (cb_out !== 3'b000 || dib !== zero_d || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_write: got cb_out=%b dib=%h mem_err=%b, required all 0", cb_out, dib, mem_err);
        end
        cb_in = 3'b000;
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        set_mar(32'h0000_0007);
        exp_q.push_back(model[7]);
        cpu_req(B_OE, lat, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || dib !== e) begin n_fail++; $display("FAIL rst_write_untouched: got %h, required %h", dib, e); end
    endtask

    task automatic test_bounds;
        int lat; bit to;
        logic [DW-1:0] e;
        set_mar(32'h0000_0000);
        write_word(32'h0BAD_F00D, 0);
        set_mar(32'h0000_0400);
`ifdef JANUS_MEM_BOUNDS_EN
        n_checks++;
        if (mem_err !== 1'b1) begin n_fail++; $display("FAIL bounds_err_set: got %b, required 1", mem_err); end
        exp_q.push_back(32'h0000_0000);
        cpu_req(B_OE, lat, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || lat != WC + 2 || dib !== e) begin n_fail++; $display("FAIL bounds_rd_zero: got %h lat %0d, required %h lat %0d", dib, lat, e, WC + 2); end
        dob = 32'hFFFF_FFFF;
        cpu_req(B_WR, lat, to);
        n_checks++;
        if (to || lat != WC + 2) begin n_fail++; $display("FAIL bounds_wr_ack: got %0d edges, required %0d", lat, WC + 2); end
        set_mar(32'h0000_0000);
        n_checks++;
        if (mem_err !== 1'b0) begin n_fail++; $display("FAIL bounds_err_clear: got %b, required 0", mem_err); end
        exp_q.push_back(model[0]);
        cpu_req(B_OE, lat, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || dib !== e) begin n_fail++; $display("FAIL bounds_wr_suppressed: got %h, required %h", dib, e); end
`else
        n_checks++;
        if (mem_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err_low: got %b, required 0", mem_err); end
        exp_q.push_back(model[0]);
        cpu_req(B_OE, lat, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || dib !== e) begin n_fail++; $display("FAIL wrap_rd: got %h, required %h", dib, e); end
`endif
    endtask

    task automatic test_halt;
        int lat; bit to;
        bit seen;
        logic [DW-1:0] e;
        set_mar(32'h0000_0005);
        halt = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model[5]);
        cb_in[B_OE] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (cb_out != 3'b000) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL halt_block: got an ack while halted, required none"); end
        halt = 1'b0;
        cpu_req(B_OE, lat, to);
        n_checks++;
        if (to || lat != WC + 2) begin n_fail++; $display("FAIL halt_release_latency: got %0d edges, required %0d", lat, WC + 2); end
        e = exp_q.pop_front();
        n_checks++;
        if (dib !== e) begin n_fail++; $display("FAIL halt_rd_data: got %h, required %h", dib, e); end
    endtask

    task automatic test_early_drop;
        int lat; bit to;
        int hi_cycles;
        logic [DW-1:0] e;
        set_mar(32'h0000_0009);
        dob = 32'h9999_0009;
        model[9] = 32'h9999_0009;
        cb_in[B_WR] = 1'b1;
        @(posedge clk); #1;
        cb_in[B_WR] = 1'b0;
        hi_cycles = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cb_out[B_WR]) hi_cycles++;
        end
        n_checks++;
        if (hi_cycles != 1) begin n_fail++; $display("FAIL early_drop_ack: got %0d ack cycles, required 1", hi_cycles); end
        exp_q.push_back(model[9]);
        cpu_req(B_OE, lat, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || dib !== e) begin n_fail++; $display("FAIL early_drop_data: got %h, required %h", dib, e); end
    endtask

    initial begin
        test_reset();
        test_mar();
        test_write_read();
        test_arbitration();
        test_reset_mid_write();
        test_bounds();
        test_halt();
        test_early_drop();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
